eq_band_scheduler: RTL and testbench
====================================

# eq_band_scheduler

Time-multiplexed IIR engine for the equalizer. It runs all NBANDS band filters (bass/mid/treble) on each incoming audio sample using a single shared multiply-accumulate unit. It sequences per-band state updates and holds double-buffered runtime-writable coefficients. It sits between the I2S receive sample strobe and the band-gain mixer, and emits one result per band per sample.

## Interface
- WD_IN, 24: input/output sample width (signed)
- WD_CO, 32: coefficient width (signed, Q(WD_CO-FRAC).FRAC)
- N, 5: filter order + 1
- NBANDS, 3: number of bands
- FRAC, 28: coefficient fraction bits
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- sample_valid  in  1  one-cycle strobe, sample_in valid
- sample_in  in  WD_IN  signed input sample
- coef_we  in  1  shadow coefficient write
- coef_band  in  $clog2(NBANDS)  band select for write
- coef_idx  in  $clog2(2N-1)  0..N-1 = b0..b(N-1); N..2N-2 = a0..a(N-2)
- coef_data  in  WD_CO  coefficient value
- coef_commit  in  1  request shadow→active swap
- overrun_clr  in  1  clears overrun
- busy  out  1  sequence in progress
- out_valid  out  1  one-cycle strobe per band result
- out_band  out  $clog2(NBANDS)  band of out_data
- out_data  out  WD_IN  signed band output
- done  out  1  one-cycle strobe after last band
- coef_pending  out  1  commit requested, swap not yet applied
- overrun  out  1  sticky: sample_valid arrived while busy

## Operation
- Transposed DF-II per band, per sample x:
  - y = (s[0] + b0·x) >>> FRAC, then reduced to WD_IN.
  - s[i] = s[i+1] + b[i+1]·x − a[i]·y for i = 0..N-2, with s[N-1] ≡ 0.
- Storage: N-1 states per band, each WD_CO+WD_IN+1 bits. Products are WD_CO+WD_IN bits.
- State index i is processed in ascending order, so each update uses the old s[i+1].
- FSM states: IDLE, LOAD, CALC_Y, UPD_B, UPD_A, EMIT.
  - IDLE→LOAD on sample_valid: latch x. If coef_pending, copy shadow→active and clear coef_pending. Set band=0.
  - CALC_Y: acc = s[0] + b0·x; y = reduce(acc >>> FRAC).
  - UPD_B(i): acc = s[i+1] + b[i+1]·x.
  - UPD_A(i): s[i] ← acc − a[i]·y. i++; after i = N-2 go to EMIT, otherwise back to UPD_B.
  - EMIT: out_valid=1, out_band=band, out_data=y. If band < NBANDS-1: band++, go to CALC_Y. Otherwise done=1, go to IDLE.
- Reduction to WD_IN is a two's-complement truncation, or saturation (see Configuration). The reduced y is also the value used for feedback.
- Coefficient writes always go to the shadow bank. coef_commit sets coef_pending. Repeated commits before the swap collapse into one.
- A coef_we in the LOAD cycle lands in shadow only; the swap copies the pre-write shadow contents.
- A coef_commit in the LOAD cycle takes effect at the next sample.
- sample_valid while busy: the sample is dropped and overrun is set. Simultaneous overrun_clr and a new overrun leaves overrun = 1.

## Timing
- Reset values:
  - All outputs 0.
  - States 0; FSM in IDLE.
  - Active and shadow coefficient banks: b0 = 1<<FRAC, all others 0 (passthrough).
- Cycles per band = 2N: CALC_Y 1 + 2(N-1) updates + EMIT 1.
- sample_valid at cycle 0 → LOAD at cycle 1 → first out_valid at cycle 1+2N → done at cycle 1+NBANDS·2N.
  - Defaults: 11, 21, 31. done coincides with the last out_valid.
- busy is high from LOAD through the last EMIT inclusive. The next sample is accepted in the cycle after done.
- An async reset mid-sequence aborts the sequence immediately: no out_valid or done follows, and coefficients return to passthrough.

## Configuration
- EQ_SAT_EN defined: y saturates to [−2^(WD_IN−1), 2^(WD_IN−1)−1].
- EQ_SAT_EN undefined: y is the low WD_IN bits (wraps).

## Structure
- Package eq_pkg holds:
  - width and FRAC constants;
  - the FSM state enum;
  - the coefficient index layout (B_BASE=0, A_BASE=N);
  - the y reduction function, which implements the EQ_SAT_EN behaviour.
- Sub-module eq_mac: one signed multiplier plus add/subtract into the accumulator, with the operand select driven by the FSM.

## Test plan
- Reset passthrough: sample 0x100000 → bands 0,1,2 output 0x100000 at cycles 11/21/31; done at cycle 31.
- Commit: write band1 b0 = 0x08000000 without commit, sample 0x200000 → all bands 0x200000. Then commit, sample 0x200000 → band1 0x100000, others 0x200000; coef_pending falls at LOAD.
- Recursion: band0 a0 = 0xF8000000 (−0.5), commit; impulse 0x400000 then zeros → band0 outputs 0x400000, 0x200000, 0x100000.
- Overrun: second sample_valid at cycle 5 → ignored, overrun = 1 until overrun_clr; the first sequence's outputs are unchanged.
- Saturation: b0 = 0x20000000 (2.0), sample 0x600000 → 0x7FFFFF with EQ_SAT_EN, 0xC00000 without.
- Reset at cycle 15 → outputs 0, busy 0, no done. The next sample gives a passthrough result.

Source files
------------

// File: rtl/eq_pkg.sv
// Shared constants, FSM state encoding, coefficient layout and output reduction for eq_band_scheduler.
// Defining EQ_SAT_EN makes band outputs saturate; when it is undefined they wrap.
package eq_pkg;

  localparam int WD_IN  = 24;
  localparam int WD_CO  = 32;
  localparam int N      = 5;
  localparam int NBANDS = 3;
  localparam int FRAC   = 28;

  localparam int PROD_W = WD_CO + WD_IN;
  localparam int ST_W   = PROD_W + 1;
  localparam int NCOEF  = 2 * N - 1;
  localparam int B_BASE = 0;
  localparam int A_BASE = N;
  localparam int BAND_W = $clog2(NBANDS);
  localparam int IDX_W  = $clog2(NCOEF);
  localparam int SI_W   = $clog2(N - 1);

  localparam logic [WD_CO-1:0] COEF_ONE = WD_CO'(64'd1 << FRAC);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    CALC_Y = 3'd2,
    UPD_B  = 3'd3,
    UPD_A  = 3'd4,
    EMIT   = 3'd5
  } eq_state_e;

  // Reduce the already-shifted accumulator to an output sample.
  function automatic logic [WD_IN-1:0] reduce_y(input logic signed [ST_W-1:0] v);
`ifdef EQ_SAT_EN
    logic signed [ST_W-1:0] hi;
    logic signed [ST_W-1:0] lo;
    hi = {{(ST_W-WD_IN+1){1'b0}}, {(WD_IN-1){1'b1}}};
    lo = {{(ST_W-WD_IN+1){1'b1}}, {(WD_IN-1){1'b0}}};
    if (v > hi) begin
      reduce_y = hi[WD_IN-1:0];
    end else if (v < lo) begin
      reduce_y = lo[WD_IN-1:0];
    end else begin
      reduce_y = v[WD_IN-1:0];
    end
`else
    reduce_y = v[WD_IN-1:0];
`endif
  endfunction

endpackage

// File: rtl/eq_mac.sv
// Shared multiply-accumulate for the band scheduler: o_sum = i_base +/- i_coef * i_data.
// Operands are selected by the scheduler FSM; the accumulator register lives in the top.
module eq_mac
  import eq_pkg::*;
(
  input  logic signed [WD_CO-1:0] i_coef,
  input  logic signed [WD_IN-1:0] i_data,
  input  logic signed [ST_W-1:0]  i_base,
  input  logic                    i_sub,
  output logic signed [ST_W-1:0]  o_sum
);

  logic signed [PROD_W-1:0] w_coef_ext;
  logic signed [PROD_W-1:0] w_data_ext;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ST_W-1:0]   w_prod_ext;

  assign w_coef_ext = PROD_W'(i_coef);
  assign w_data_ext = PROD_W'(i_data);
  assign w_prod     = w_coef_ext * w_data_ext;
  assign w_prod_ext = ST_W'(w_prod);

  // Add or subtract the product into the supplied base value.
  always_comb begin
    o_sum = i_base;
    if (i_sub) begin
      o_sum = i_base - w_prod_ext;
    end else begin
      o_sum = i_base + w_prod_ext;
    end
  end

endmodule

// File: rtl/eq_band_scheduler.sv
// Time-multiplexed transposed DF-II IIR engine: runs every band on each sample through one MAC,
// with double-buffered coefficients. Widths come from eq_pkg; EQ_SAT_EN selects saturating outputs.
module eq_band_scheduler
  import eq_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample_valid,
  input  logic [WD_IN-1:0]  sample_in,
  input  logic              coef_we,
  input  logic [BAND_W-1:0] coef_band,
  input  logic [IDX_W-1:0]  coef_idx,
  input  logic [WD_CO-1:0]  coef_data,
  input  logic              coef_commit,
  input  logic              overrun_clr,
  output logic              busy,
  output logic              out_valid,
  output logic [BAND_W-1:0] out_band,
  output logic [WD_IN-1:0]  out_data,
  output logic              done,
  output logic              coef_pending,
  output logic              overrun
);

  eq_state_e                r_fsm;
  logic [BAND_W-1:0]        r_band;
  logic [SI_W-1:0]          r_i;
  logic signed [WD_IN-1:0]  r_x;
  logic signed [WD_IN-1:0]  r_y;
  logic signed [ST_W-1:0]   r_acc;
  logic signed [ST_W-1:0]   r_state [NBANDS][N-1];
  logic [WD_CO-1:0]         r_act   [NBANDS][NCOEF];
  logic [WD_CO-1:0]         r_shd   [NBANDS][NCOEF];
  logic                     r_busy;
  logic                     r_out_valid;
  logic [BAND_W-1:0]        r_out_band;
  logic [WD_IN-1:0]         r_out_data;
  logic                     r_done;
  logic                     r_pend;
  logic                     r_overrun;

  logic signed [WD_CO-1:0]  w_coef;
  logic signed [WD_IN-1:0]  w_data;
  logic signed [ST_W-1:0]   w_base;
  logic                     w_sub;
  logic signed [ST_W-1:0]   w_sum;
  logic signed [ST_W-1:0]   w_shift;
  logic [SI_W-1:0]          w_i_nx;
  logic [IDX_W-1:0]         w_b_idx;
  logic [IDX_W-1:0]         w_a_idx;
  logic                     w_last_i;
  logic                     w_last_band;
  logic                     w_accept;

  assign w_i_nx      = r_i + SI_W'(1);
  assign w_b_idx     = IDX_W'(r_i) + IDX_W'(B_BASE + 1);
  assign w_a_idx     = IDX_W'(r_i) + IDX_W'(A_BASE);
  assign w_last_i    = (r_i == SI_W'(N - 2));
  assign w_last_band = (r_band == BAND_W'(NBANDS - 1));
  assign w_accept    = (r_fsm == IDLE) && sample_valid;
  assign w_shift     = w_sum >>> FRAC;

  // MAC operand selection per FSM phase; the top state s[N-1] is implicitly zero.
  always_comb begin
    w_base = '0;
    w_coef = '0;
    w_data = '0;
    w_sub  = 1'b0;
    case (r_fsm)
      CALC_Y: begin
        w_base = r_state[r_band][0];
        w_coef = r_act[r_band][B_BASE];
        w_data = r_x;
      end
      UPD_B: begin
        if (w_last_i) begin
          w_base = '0;
        end else begin
          w_base = r_state[r_band][w_i_nx];
        end
        w_coef = r_act[r_band][w_b_idx];
        w_data = r_x;
      end
      UPD_A: begin
        w_base = r_acc;
        w_coef = r_act[r_band][w_a_idx];
        w_data = r_y;
        w_sub  = 1'b1;
      end
      default: begin
        w_sub = 1'b0;
      end
    endcase
  end

  eq_mac u_mac (
    .i_coef (w_coef),
    .i_data (w_data),
    .i_base (w_base),
    .i_sub  (w_sub),
    .o_sum  (w_sum)
  );

  // Sequencer FSM with registered status and result outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fsm       <= IDLE;
      r_band      <= '0;
      r_i         <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_acc       <= '0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_band  <= '0;
      r_out_data  <= '0;
      r_done      <= 1'b0;
      r_pend      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= (sample_valid & (r_fsm != IDLE)) | (r_overrun & ~overrun_clr);
      r_pend      <= coef_commit | (r_pend & ~w_accept);
      case (r_fsm)
        IDLE: begin
          if (sample_valid) begin
            r_fsm  <= LOAD;
            r_x    <= sample_in;
            r_band <= '0;
            r_busy <= 1'b1;
          end
        end
        LOAD: begin
          r_i   <= '0;
          r_fsm <= CALC_Y;
        end
        CALC_Y: begin
          r_y   <= reduce_y(w_shift);
          r_fsm <= UPD_B;
        end
        UPD_B: begin
          r_acc <= w_sum;
          r_fsm <= UPD_A;
        end
        UPD_A: begin
          if (w_last_i) begin
            r_fsm       <= EMIT;
            r_out_valid <= 1'b1;
            r_out_band  <= r_band;
            r_out_data  <= r_y;
            r_done      <= w_last_band;
          end else begin
            r_i   <= w_i_nx;
            r_fsm <= UPD_B;
          end
        end
        EMIT: begin
          if (w_last_band) begin
            r_fsm  <= IDLE;
            r_busy <= 1'b0;
          end else begin
            r_band <= r_band + BAND_W'(1);
            r_i    <= '0;
            r_fsm  <= CALC_Y;
          end
        end
        default: begin
          r_fsm  <= IDLE;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  // Per-band filter state; s[i] is rewritten in UPD_A after s[i+1] was consumed in UPD_B.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < NBANDS; b++) begin
        for (int s = 0; s < N - 1; s++) begin
          r_state[b][s] <= '0;
        end
      end
    end else if (r_fsm == UPD_A) begin
      r_state[r_band][r_i] <= w_sum;
    end
  end

  // Coefficient banks: writes hit shadow; the swap copies pre-write shadow when a sample is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < NBANDS; b++) begin
        for (int c = 0; c < NCOEF; c++) begin
          r_act[b][c] <= (c == B_BASE) ? COEF_ONE : '0;
          r_shd[b][c] <= (c == B_BASE) ? COEF_ONE : '0;
        end
      end
    end else begin
      if (w_accept && r_pend) begin
        r_act <= r_shd;
      end
      if (coef_we && (coef_band < BAND_W'(NBANDS)) && (coef_idx < IDX_W'(NCOEF))) begin
        r_shd[coef_band][coef_idx] <= coef_data;
      end
    end
  end

  assign busy         = r_busy;
  assign out_valid    = r_out_valid;
  assign out_band     = r_out_band;
  assign out_data     = r_out_data;
  assign done         = r_done;
  assign coef_pending = r_pend;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_eq_band_scheduler.sv
// Directed, table-driven bench for eq_band_scheduler with hand-computed expected outputs,
// plus hand-written sequences for overrun, LOAD-cycle coefficient traffic and mid-sequence reset.
module tb_eq_band_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [23:0] sample_in = 24'h0;
  logic        coef_we = 1'b0;
  logic [1:0]  coef_band = 2'd0;
  logic [3:0]  coef_idx = 4'd0;
  logic [31:0] coef_data = 32'h0;
  logic        coef_commit = 1'b0;
  logic        overrun_clr = 1'b0;
  logic        busy, out_valid, done, coef_pending, overrun;
  logic [1:0]  out_band;
  logic [23:0] out_data;

  int n_checks = 0;
  int n_errors = 0;

  eq_band_scheduler dut (
    .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid), .sample_in(sample_in),
    .coef_we(coef_we), .coef_band(coef_band), .coef_idx(coef_idx), .coef_data(coef_data),
    .coef_commit(coef_commit), .overrun_clr(overrun_clr), .busy(busy), .out_valid(out_valid),
    .out_band(out_band), .out_data(out_data), .done(done), .coef_pending(coef_pending),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [1:0]  wband;
    logic [3:0]  widx;
    logic [31:0] wdata;
    logic        commit;
    logic [23:0] x;
    logic [23:0] e0;
    logic [23:0] e1;
    logic [23:0] e2;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  int          ov_n, done_n, done_c;
  int          ov_c [8];
  logic [1:0]  ov_b [8];
  logic [23:0] ov_d [8];
  logic        busy1, busy31, busy32, pend1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic write_coef(input logic [1:0] b, input logic [3:0] idx, input logic [31:0] d);
    @(negedge clk);
    coef_we = 1'b1; coef_band = b; coef_idx = idx; coef_data = d;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic do_commit();
    @(negedge clk);
    coef_commit = 1'b1;
    @(negedge clk);
    coef_commit = 1'b0;
  endtask

  // Sample x is strobed in cycle 0; outputs are observed at negedges of cycles 1..33.
  task automatic run_sample(input logic [23:0] x);
    ov_n = 0; done_n = 0; done_c = -1;
    @(negedge clk);
    sample_valid = 1'b1;
    sample_in = x;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      if (c == 1) begin
        sample_valid = 1'b0;
        busy1 = busy;
        pend1 = coef_pending;
      end
      if (out_valid) begin
        if (ov_n < 8) begin
          ov_c[ov_n] = c; ov_b[ov_n] = out_band; ov_d[ov_n] = out_data;
        end
        ov_n++;
      end
      if (done) begin
        done_n++;
        done_c = c;
      end
      if (c == 31) busy31 = busy;
      if (c == 32) busy32 = busy;
    end
  endtask

  task automatic check_run(input logic [23:0] x, input logic [23:0] e0,
                           input logic [23:0] e1, input logic [23:0] e2);
    logic [23:0] exp_d [3];
    exp_d[0] = e0; exp_d[1] = e1; exp_d[2] = e2;
    run_sample(x);
    chk("out_valid_count", ov_n, 3);
    for (int k = 0; k < 3; k++) begin
      if (k < ov_n) begin
        chk($sformatf("out_cycle[%0d]", k), ov_c[k], 11 + 10 * k);
        chk($sformatf("out_band[%0d]", k), ov_b[k], k);
        chk($sformatf("out_data[%0d] x=%h", k, x), ov_d[k], exp_d[k]);
      end
    end
    chk("done_count", done_n, 1);
    chk("done_cycle", done_c, 31);
    chk("busy_at_load", busy1, 1);
    chk("busy_at_31", busy31, 1);
    chk("busy_at_32", busy32, 0);
    chk("pending_at_load", pend1, 0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_band"}, out_band, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pending"}, coef_pending, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  initial begin
    logic [23:0] sat_p, sat_n;
    int          cnt2;
    logic [23:0] last2;
    int          done2;
`ifdef EQ_SAT_EN
    sat_p = 24'h7FFFFF;
    sat_n = 24'h800000;
`else
    sat_p = 24'hC00000;
    sat_n = 24'h400000;
`endif
    //            we    band  idx   data           commit x          e0         e1         e2
    vecs[0] = '{1'b0, 2'd0, 4'd0, 32'h00000000, 1'b0, 24'h100000, 24'h100000, 24'h100000, 24'h100000};
    vecs[1] = '{1'b1, 2'd1, 4'd0, 32'h08000000, 1'b0, 24'h200000, 24'h200000, 24'h200000, 24'h200000};
    vecs[2] = '{1'b0, 2'd0, 4'd0, 32'h00000000, 1'b1, 24'h200000, 24'h200000, 24'h100000, 24'h200000};
    vecs[3] = '{1'b1, 2'd0, 4'd5, 32'hF8000000, 1'b1, 24'h400000, 24'h400000, 24'h200000, 24'h400000};
    vecs[4] = '{1'b0, 2'd0, 4'd0, 32'h00000000, 1'b0, 24'h000000, 24'h200000, 24'h000000, 24'h000000};
    vecs[5] = '{1'b0, 2'd0, 4'd0, 32'h00000000, 1'b0, 24'h000000, 24'h100000, 24'h000000, 24'h000000};
    vecs[6] = '{1'b1, 2'd0, 4'd5, 32'h00000000, 1'b1, 24'h000000, 24'h080000, 24'h000000, 24'h000000};
    vecs[7] = '{1'b1, 2'd2, 4'd0, 32'h20000000, 1'b1, 24'h600000, 24'h600000, 24'h300000, sat_p};
    vecs[8] = '{1'b0, 2'd0, 4'd0, 32'h00000000, 1'b0, 24'hF00000, 24'hF00000, 24'hF80000, 24'hE00000};
    vecs[9] = '{1'b0, 2'd0, 4'd0, 32'h00000000, 1'b0, 24'hA00000, 24'hA00000, 24'hD00000, sat_n};

    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < NV; v++) begin
      if (vecs[v].we) write_coef(vecs[v].wband, vecs[v].widx, vecs[v].wdata);
      if (vecs[v].commit) begin
        do_commit();
        chk($sformatf("pending_set[%0d]", v), coef_pending, 1);
      end
      check_run(vecs[v].x, vecs[v].e0, vecs[v].e1, vecs[v].e2);
    end

    // Overrun: drops at cycles 5, 8 (with clear) and 31; sample at cycle 32 is accepted.
    fork
      check_run(24'h010000, 24'h010000, 24'h008000, 24'h020000);
      begin
        repeat (6) @(negedge clk);
        sample_valid = 1'b1; sample_in = 24'h7FFFFF;
        @(negedge clk);
        sample_valid = 1'b0;
        chk("overrun_set", overrun, 1);
        repeat (2) @(negedge clk);
        sample_valid = 1'b1; overrun_clr = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0; overrun_clr = 1'b0;
        chk("overrun_clr_vs_set", overrun, 1);
        repeat (11) @(negedge clk);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        chk("overrun_cleared", overrun, 0);
        repeat (10) @(negedge clk);
        sample_valid = 1'b1;
        @(negedge clk);
        chk("overrun_last_emit", overrun, 1);
        sample_in = 24'h000100;
        @(negedge clk);
        sample_valid = 1'b0;
        chk("busy_after_done_accept", busy, 1);
      end
    join
    cnt2 = 0; last2 = 24'h0; done2 = 0;
    for (int c = 0; c < 35; c++) begin
      @(negedge clk);
      if (out_valid) begin
        cnt2++;
        last2 = out_data;
      end
      if (done) done2++;
    end
    chk("b2b_out_count", cnt2, 3);
    chk("b2b_last_data", last2, 24'h000200);
    chk("b2b_done_count", done2, 1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    chk("overrun_final_clear", overrun, 0);

    // Write and commit during LOAD: current sample uses old shadow, new value needs the next sample.
    write_coef(2'd0, 4'd0, 32'h08000000);
    do_commit();
    fork
      check_run(24'h100000, 24'h080000, 24'h080000, 24'h200000);
      begin
        repeat (2) @(negedge clk);
        coef_we = 1'b1; coef_band = 2'd0; coef_idx = 4'd0; coef_data = 32'h04000000;
        coef_commit = 1'b1;
        @(negedge clk);
        coef_we = 1'b0; coef_commit = 1'b0;
      end
    join
    chk("pending_from_load_commit", coef_pending, 1);
    check_run(24'h100000, 24'h040000, 24'h080000, 24'h200000);

    // Asynchronous reset in cycle 15 aborts the sequence and restores passthrough coefficients.
    fork
      run_sample(24'h0ABCDE);
      begin
        repeat (16) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_idle_outputs("midreset");
        @(negedge clk);
        reset_n = 1'b1;
      end
    join
    chk("midreset_out_count", ov_n, 1);
    chk("midreset_done_count", done_n, 0);
    check_run(24'h123456, 24'h123456, 24'h123456, 24'h123456);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
